// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: FSM state codes,
// per-stage stall vectors and the request-priority encoder.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // stall[0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 stops that stage.
    // Each pattern freezes the requesting stage and everything before it,
    // leaving the following stage free to take a bubble.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // Later stages win: a MEM wait must freeze everything EX would freeze too.
    function automatic logic [5:0] stall_pattern(input logic req_if, input logic req_id,
                                                 input logic req_ex, input logic req_mem);
        logic [5:0] pat;
        pat = STALL_NONE;
        if (req_mem)     pat = STALL_MEM;
        else if (req_ex) pat = STALL_EX;
        else if (req_id) pat = STALL_ID;
        else if (req_if) pat = STALL_IF;
        return pat;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky error
// once the run length reaches LIMIT. Observes only; never alters stall/flush.
module pipe_ctrl_stall_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_any,
    output logic wdog_err
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] run_q, run_d;
    logic         err_q, err_d;

    // Run length clears on any free cycle and parks at LIMIT; error is sticky.
    always_comb begin
        run_d = run_q;
        err_d = err_q;
        if (!stall_any)        run_d = '0;
        else if (run_q != LIM) run_d = run_q + W'(1);
        if (run_d == LIM)      err_d = 1'b1;
    end

    // State registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign wdog_err = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Stall vector is combinational from the stage requests; flushes are
// sequenced by a small FSM that defers a redirect while MEM is waiting.
// Optional watchdog: define PIPE_CTRL_WATCHDOG_EN to build the consecutive
// stall timeout (wdog_err); otherwise wdog_err is tied low.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             wdog_err
);

    state_e             state_q, state_d;
    logic [31:0]        new_pc_q, new_pc_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Stall vector: priority-encoded requests, suppressed during the flush cycle.
    always_comb begin
        stall = stall_pattern(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        if (state_q == ST_FLUSH) stall = STALL_NONE;
    end

    // Flush sequencing: a redirect issues at once unless MEM is waiting, in
    // which case it is parked (latest target wins) until the wait clears.
    always_comb begin
        state_d   = state_q;
        new_pc_d  = new_pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            ST_PEND: begin
                if (!stallreq_mem) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = flush_req ? flush_pc : pend_pc_q;
                end else if (flush_req) begin
                    pend_pc_d = flush_pc;
                end
            end
            default: begin
                // IDLE and FLUSH share this: back-to-back flushes are legal.
                state_d = ST_IDLE;
                if (flush_req) begin
                    if (!stallreq_mem) begin
                        state_d  = ST_FLUSH;
                        new_pc_d = flush_pc;
                    end else begin
                        state_d   = ST_PEND;
                        pend_pc_d = flush_pc;
                    end
                end
            end
        endcase
    end

    // Stall-cycle counter: counts frozen-PC cycles, saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall[0] && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers, synchronous reset; a parked flush is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            new_pc_q  <= ZERO_WORD;
            pend_pc_q <= ZERO_WORD;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            new_pc_q  <= new_pc_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign flush        = (state_q == ST_FLUSH);
    assign new_pc       = new_pc_q;
    assign stall_cycles = cnt_q;

`ifdef PIPE_CTRL_WATCHDOG_EN
    pipe_ctrl_stall_watchdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .stall_any(|stall),
        .wdog_err (wdog_err)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_err          = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: priority table, directed flush/counter
// sequences, then random traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int LIMIT = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             r_if, r_id, r_ex, r_mem, f_req;
    logic [31:0]      f_pc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cycles;
    logic             wdog_err;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.CNT_W(CNT_W), .WDOG_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(r_if), .stallreq_id(r_id), .stallreq_ex(r_ex), .stallreq_mem(r_mem),
        .flush_req(f_req), .flush_pc(f_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cycles(stall_cycles), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: "is a flush showing now", "is a redirect parked".
    bit          m_flush, m_pending, m_werr;
    logic [31:0] m_new_pc, m_pend_pc;
    int          m_cnt, m_run;

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Deepest requesting stage k (if=1..mem=4) stops stages 0..k.
    function automatic logic [5:0] model_stall();
        int deep;
        deep = 0;
        if (r_if)  deep = 1;
        if (r_id)  deep = 2;
        if (r_ex)  deep = 3;
        if (r_mem) deep = 4;
        if (m_flush || deep == 0) return 6'd0;
        return 6'((1 << (deep + 1)) - 1);
    endfunction

    task automatic model_reset();
        m_flush = 0; m_pending = 0; m_werr = 0;
        m_new_pc = 0; m_pend_pc = 0; m_cnt = 0; m_run = 0;
    endtask

    task automatic model_step();
        logic [5:0] s;
        bit nf;
        s  = model_stall();
        nf = 0;
        if (m_pending) begin
            if (!r_mem) begin
                nf = 1; m_pending = 0;
                m_new_pc = f_req ? f_pc : m_pend_pc;
            end else if (f_req) m_pend_pc = f_pc;
        end else if (f_req) begin
            if (!r_mem) begin nf = 1; m_new_pc = f_pc; end
            else begin m_pending = 1; m_pend_pc = f_pc; end
        end
        if (s[0] && m_cnt < CMAX) m_cnt++;
        if (s != 0) m_run++; else m_run = 0;
        if (WDOG && m_run >= LIMIT) m_werr = 1;
        m_flush = nf;
        if (rst) model_reset();
    endtask

    // One clock: compare at negedge, advance model, return 1 time unit after posedge.
    task automatic cyc();
        @(negedge clk);
        chk("m_stall",  32'(stall),        32'(model_stall()));
        chk("m_flush",  32'(flush),        32'(m_flush));
        chk("m_new_pc", new_pc,            m_new_pc);
        chk("m_cnt",    32'(stall_cycles), 32'(m_cnt));
        chk("m_wdog",   32'(wdog_err),     32'(m_werr));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {r_mem, r_ex, r_id, r_if} = r;
    endtask

    task automatic do_reset();
        rst = 1; f_req = 0; set_req(4'b0);
        cyc();
        rst = 0;
    endtask

    typedef struct {
        logic [3:0] req;   // {mem, ex, id, if}
        logic [5:0] exp;
    } vec_t;
    vec_t vt[16];

    initial begin
        vt[0]  = '{4'b0000, 6'b000000}; vt[1]  = '{4'b0001, 6'b000011};
        vt[2]  = '{4'b0010, 6'b000111}; vt[3]  = '{4'b0011, 6'b000111};
        vt[4]  = '{4'b0100, 6'b001111}; vt[5]  = '{4'b0101, 6'b001111};
        vt[6]  = '{4'b0110, 6'b001111}; vt[7]  = '{4'b0111, 6'b001111};
        vt[8]  = '{4'b1000, 6'b011111}; vt[9]  = '{4'b1001, 6'b011111};
        vt[10] = '{4'b1010, 6'b011111}; vt[11] = '{4'b1011, 6'b011111};
        vt[12] = '{4'b1100, 6'b011111}; vt[13] = '{4'b1101, 6'b011111};
        vt[14] = '{4'b1110, 6'b011111}; vt[15] = '{4'b1111, 6'b011111};

        rst = 1; f_req = 0; f_pc = 0; set_req(4'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_newpc", new_pc, 0);
        chk("rst_cnt",   32'(stall_cycles), 0);
        chk("rst_wdog",  32'(wdog_err), 0);
        rst = 0;

        // Priority table, stall has zero latency.
        for (int i = 0; i < 16; i++) begin
            set_req(vt[i].req);
            #1;
            chk($sformatf("prio_%0d", i), 32'(stall), 32'(vt[i].exp));
            cyc();
        end

        // Immediate flush.
        do_reset();
        f_req = 1; f_pc = 32'h0000_0040;
        cyc();
        f_req = 0;
        chk("t2_flush", 32'(flush), 1);
        chk("t2_newpc", new_pc, 32'h40);
        chk("t2_stall", 32'(stall), 0);
        cyc();
        chk("t2_flush_off", 32'(flush), 0);

        // Flush held off by a MEM wait.
        do_reset();
        set_req(4'b1000); f_req = 1; f_pc = 32'h80;
        cyc(); f_req = 0;
        chk("t3_hold1", 32'(flush), 0);
        cyc();
        chk("t3_hold2", 32'(flush), 0);
        cyc();
        chk("t3_hold3", 32'(flush), 0);
        set_req(4'b0);
        cyc();
        chk("t3_flush", 32'(flush), 1);
        chk("t3_newpc", new_pc, 32'h80);

        // Latest parked target wins; back-to-back flush from the FLUSH cycle.
        do_reset();
        set_req(4'b1000); f_req = 1; f_pc = 32'h1234;
        cyc();
        f_pc = 32'hBFC0_0380;
        cyc();
        f_req = 0; set_req(4'b0);
        cyc();
        chk("t4_flush", 32'(flush), 1);
        chk("t4_newpc", new_pc, 32'hBFC0_0380);
        f_req = 1; f_pc = 32'h0000_0100;
        cyc();
        f_req = 0;
        chk("t4_flush2", 32'(flush), 1);
        chk("t4_newpc2", new_pc, 32'h100);
        cyc();
        chk("t4_flush_off", 32'(flush), 0);
        chk("t4_newpc_hold", new_pc, 32'h100);

        // Counter and saturation (CNT_W=4: all-ones is 15).
        do_reset();
        set_req(4'b0100);
        repeat (10) cyc();
        chk("t5_cnt10", 32'(stall_cycles), 10);
        repeat (4) cyc();
        chk("t5_cnt14", 32'(stall_cycles), 14);
        repeat (3) cyc();
        chk("t5_sat", 32'(stall_cycles), 15);
        set_req(4'b0);

        // Watchdog.
        do_reset();
        set_req(4'b0001);
        repeat (LIMIT - 1) cyc();
        chk("t6_wdog_pre", 32'(wdog_err), 0);
        cyc();
        chk("t6_wdog_hit", 32'(wdog_err), 32'(WDOG));
        set_req(4'b0);
        repeat (2) cyc();
        chk("t6_wdog_sticky", 32'(wdog_err), 32'(WDOG));

        // Reset while a flush is parked discards it.
        do_reset();
        set_req(4'b1000); f_req = 1; f_pc = 32'h200;
        cyc();
        f_req = 0; set_req(4'b0); rst = 1;
        cyc();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_noflush", 32'(flush), 0);
            chk("t6_newpc0", new_pc, 0);
            chk("t6_cnt0", 32'(stall_cycles), 0);
            chk("t6_wdog0", 32'(wdog_err), 0);
            chk("t6_stall0", 32'(stall), 0);
            cyc();
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_req(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            f_req = ($urandom_range(0, 3) == 0);
            f_pc  = $urandom;
            rst   = ($urandom_range(0, 79) == 0);
            cyc();
        end
        rst = 0; f_req = 0; set_req(4'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
